// File: rtl/display_tilemap_scroll.sv
// Tile-map background layer on the RGBStr pixel stream: wrap-around map with
// frame-latched X/Y scroll, per-tile flips, pixel replication and a transparency key.
module display_tilemap_scroll #(
    parameter int TAB_W      = 40,
    parameter int TAB_H      = 30,
    parameter int TILE_LOG2  = 4,
    parameter int NBMP_LOG2  = 4,
    parameter int SCALE_LOG2 = 0,
    parameter int TAB_AW     = 11,
    parameter int TAB_DW     = 6,
    parameter int BMP_AW     = 12,
    parameter int PX_DW      = 3,
    parameter int TRANSP     = 0
) (
    input  logic              px_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [9:0]        scroll_x,
    input  logic [9:0]        scroll_y,
    input  logic [25:0]       RGBStr_i,
    input  logic [TAB_DW-1:0] TabDat,
    input  logic [PX_DW-1:0]  BmpDat,
    output logic [TAB_AW-1:0] TabAdd,
    output logic [BMP_AW-1:0] BmpAdd,
    output logic [25:0]       RGBStr_o
);

    // Stream word layout: {HS, VS, XC[9:0], YC[9:0], Active, RGB[PX_DW-1:0]}
    localparam int ACT_BIT = PX_DW;
    localparam int YC_LSB  = PX_DW + 1;
    localparam int XC_LSB  = PX_DW + 11;

    localparam logic [10:0] MAP_PW = 11'(TAB_W << TILE_LOG2);
    localparam logic [10:0] MAP_PH = 11'(TAB_H << TILE_LOG2);

    logic [10:0]          sx_q, sx_d, sy_q, sy_d;
    logic [TAB_AW-1:0]    tab_add_q, tab_add_d;
    logic [TILE_LOG2-1:0] offx_q, offx_d, offy_q, offy_d;
    logic [25:0]          s0_q, s1_q;
    logic                 en0_q, en1_q;
    logic [BMP_AW-1:0]    bmp_add_q, bmp_add_d;
    logic [25:0]          out_q, out_d;

    logic [9:0]  xc, yc;
    logic        origin;
    logic [10:0] sx_red, sy_red, xs, ys, vx, vy, col, row;
    logic [31:0] lin;

    always_comb begin
        xc     = RGBStr_i[XC_LSB +: 10];
        yc     = RGBStr_i[YC_LSB +: 10];
        origin = (xc == 10'd0) && (yc == 10'd0);

        sx_red = ({1'b0, scroll_x} >= MAP_PW) ? ({1'b0, scroll_x} - MAP_PW) : {1'b0, scroll_x};
        sy_red = ({1'b0, scroll_y} >= MAP_PH) ? ({1'b0, scroll_y} - MAP_PH) : {1'b0, scroll_y};

        // The newly latched scroll already applies to the origin pixel itself.
        sx_d = origin ? sx_red : sx_q;
        sy_d = origin ? sy_red : sy_q;

        xs = {1'b0, xc >> SCALE_LOG2} + sx_d;
        ys = {1'b0, yc >> SCALE_LOG2} + sy_d;
        vx = (xs >= MAP_PW) ? (xs - MAP_PW) : xs;
        vy = (ys >= MAP_PH) ? (ys - MAP_PH) : ys;

        col       = vx >> TILE_LOG2;
        row       = vy >> TILE_LOG2;
        lin       = 32'(row) * 32'(TAB_W) + 32'(col);
        tab_add_d = TAB_AW'(lin);
        offx_d    = vx[TILE_LOG2-1:0];
        offy_d    = vy[TILE_LOG2-1:0];
    end

    logic [NBMP_LOG2-1:0] idx;
    logic [TILE_LOG2-1:0] fx, fy;

    always_comb begin
        idx       = TabDat[NBMP_LOG2-1:0];
        fx        = TabDat[NBMP_LOG2]     ? ~offx_q : offx_q;
        fy        = TabDat[NBMP_LOG2 + 1] ? ~offy_q : offy_q;
        bmp_add_d = {idx, fy, fx};
    end

    always_comb begin
        out_d = s1_q;
        if (s1_q[ACT_BIT] && en1_q && (BmpDat != PX_DW'(TRANSP))) begin
            out_d[PX_DW-1:0] = BmpDat;
        end
    end

    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            sx_q      <= '0;
            sy_q      <= '0;
            tab_add_q <= '0;
            offx_q    <= '0;
            offy_q    <= '0;
            s0_q      <= '0;
            en0_q     <= 1'b0;
            bmp_add_q <= '0;
            s1_q      <= '0;
            en1_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            tab_add_q <= tab_add_d;
            offx_q    <= offx_d;
            offy_q    <= offy_d;
            s0_q      <= RGBStr_i;
            en0_q     <= en;
            bmp_add_q <= bmp_add_d;
            s1_q      <= s0_q;
            en1_q     <= en0_q;
            out_q     <= out_d;
        end
    end

    assign TabAdd   = tab_add_q;
    assign BmpAdd   = bmp_add_q;
    assign RGBStr_o = out_q;

endmodule
